// File: rtl/rv32m_pkg.sv
// rv32m_pkg: shared op codes, divider FSM states and iteration count
package rv32m_pkg;
    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } op_t;
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;
    localparam int ITERS = 32;
endpackage

// File: rtl/rv32m_divider_cla.sv
// carry_lookahead_adder: generate/propagate adder, carries resolved from g/p terms
module carry_lookahead_adder #(
    parameter int N = 33
) (
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic         in_cin,
    output logic [N-1:0] out_sum
);
    logic [N-1:0] g;
    logic [N-1:0] p;
    logic         carry;
    // sum bits from per-bit propagate xor the carry built from generate/propagate
    always_comb begin
        g     = in_a & in_b;
        p     = in_a ^ in_b;
        carry = in_cin;
        out_sum = '0;
        for (int i = 0; i < N; i++) begin
            out_sum[i] = p[i] ^ carry;
            carry      = g[i] | (p[i] & carry);
        end
    end
endmodule

// File: rtl/rv32m_divider.sv
// rv32m_divider: iterative restoring divider for RV32M DIV/DIVU/REM/REMU
module rv32m_divider
    import rv32m_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   in_op,
    input  logic [W-1:0] in_dividend,
    input  logic [W-1:0] in_divisor,
    input  logic         in_flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_result
);
    state_t       state, next_state;
    logic [5:0]   cnt;
    logic [W-1:0] dsr, quot, rem, result, fix_x;
    logic         is_rem, fix_neg;
    logic         in_signed, in_rem, a_neg, b_neg, div_zero, ovf, accept;
    logic [W:0]   cla_a, cla_b, cla_sum, shifted;

    assign in_signed = (in_op == OP_DIV) || (in_op == OP_REM);
    assign in_rem    = (in_op == OP_REM) || (in_op == OP_REMU);
    assign a_neg     = in_signed & in_dividend[W-1];
    assign b_neg     = in_signed & in_divisor[W-1];
    assign div_zero  = in_divisor == '0;
    assign ovf       = in_signed && in_dividend == {1'b1, {(W-1){1'b0}}} && (&in_divisor);
    assign accept    = in_valid & in_ready & ~in_flush;

    assign in_ready   = state == S_IDLE;
    assign out_valid  = state == S_DONE;
    assign out_result = out_valid ? result : '0;

    // the adder subtracts the divisor while iterating and negates the selected result in FIX
    assign shifted = {rem, quot[W-1]};
    assign fix_x   = is_rem ? rem : quot;
    assign cla_a   = (state == S_FIX) ? ~{1'b0, fix_x} : shifted;
    assign cla_b   = (state == S_FIX) ? '0 : ~{1'b0, dsr};

    carry_lookahead_adder #(.N(W + 1)) u_cla (
        .in_a   (cla_a),
        .in_b   (cla_b),
        .in_cin (1'b1),
        .out_sum(cla_sum)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    // next state; special-case operands jump straight to FIX with a ready-made result
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (in_valid) next_state = (div_zero || ovf) ? S_FIX : S_CALC;
            S_CALC:  if (cnt == 6'(ITERS - 1)) next_state = S_FIX;
            S_FIX:   next_state = S_DONE;
            S_DONE:  if (out_ready) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
        if (in_flush) next_state = S_IDLE;
    end

    // operand capture, restoring iterations and final sign fix-up
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            dsr     <= '0;
            quot    <= '0;
            rem     <= '0;
            result  <= '0;
            is_rem  <= 1'b0;
            fix_neg <= 1'b0;
        end else if (accept) begin
            cnt     <= '0;
            dsr     <= b_neg ? -in_divisor : in_divisor;
            quot    <= div_zero ? '1 : ovf ? in_dividend : a_neg ? -in_dividend : in_dividend;
            rem     <= div_zero ? in_dividend : '0;
            is_rem  <= in_rem;
            fix_neg <= (div_zero || ovf) ? 1'b0 : in_rem ? a_neg : a_neg ^ b_neg;
        end else if (state == S_CALC) begin
            rem  <= cla_sum[W] ? shifted[W-1:0] : cla_sum[W-1:0];
            quot <= {quot[W-2:0], ~cla_sum[W]};
            cnt  <= (cnt == 6'(ITERS)) ? cnt : cnt + 6'd1;
        end else if (state == S_FIX) begin
            result <= fix_neg ? cla_sum[W-1:0] : fix_x;
        end
    end
endmodule

// File: tb/tb_rv32m_divider.sv
// tb_rv32m_divider: directed and random checks of rv32m_divider against an arithmetic model
module tb_rv32m_divider;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_flush = 1'b0;
    logic        out_ready = 1'b0;
    logic [1:0]  in_op = 2'b00;
    logic [31:0] in_dividend = '0;
    logic [31:0] in_divisor = '0;
    logic        in_ready, out_valid;
    logic [31:0] out_result;
    int          passed = 0;
    int          total = 0;

    rv32m_divider #(.W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_dividend(in_dividend),
        .in_divisor (in_divisor),
        .in_flush   (in_flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        return b == 32'd0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
        case (op)
            2'b00:   return 32'($signed(a) / $signed(b));
            2'b01:   return a / b;
            2'b10:   return 32'($signed(a) % $signed(b));
            default: return a % b;
        endcase
    endfunction

    task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int hold, input string tag);
        int lat;
        logic [31:0] exp;
        exp = model(op, a, b);
        @(negedge clk);
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_op = op; in_dividend = a; in_divisor = b;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), special(op, a, b) ? 32'd1 : 32'd33);
        check({tag, ".result"}, out_result, exp);
        repeat (hold) begin
            @(negedge clk);
            check({tag, ".hold_result"}, out_result, exp);
            check({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        if (hold > 0) check({tag, ".in_ready_before_accept"}, 32'(in_ready), 32'd0);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, ".out_valid_after"}, 32'(out_valid), 32'd0);
        check({tag, ".in_ready_after"}, 32'(in_ready), 32'd1);
        check({tag, ".zero_result_idle"}, out_result, 32'd0);
    endtask

    initial begin
        int seen;
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        #12;
        check("reset.in_ready", 32'(in_ready), 32'd1);
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.out_result", out_result, 32'd0);
        rst_n = 1'b1;

        run(2'b01, 32'd100, 32'd7, 0, "divu_100_7");
        run(2'b11, 32'd100, 32'd7, 0, "remu_100_7");
        run(2'b00, -32'sd7, 32'd2, 0, "div_m7_2");
        run(2'b10, -32'sd7, 32'd2, 0, "rem_m7_2");
        run(2'b00, 32'd7, -32'sd2, 0, "div_7_m2");
        run(2'b10, 32'd7, -32'sd2, 0, "rem_7_m2");
        run(2'b01, 32'd5, 32'd0, 0, "divu_5_0");
        run(2'b10, 32'd5, 32'd0, 0, "rem_5_0");
        run(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
        run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, "rem_ovf");
        run(2'b01, 32'd100, 32'd7, 10, "hold_divu");
        check("model_divu_100_7", model(2'b01, 32'd100, 32'd7), 32'd14);

        @(negedge clk);
        in_valid = 1'b1; in_flush = 1'b1; in_op = 2'b01; in_dividend = 32'd50; in_divisor = 32'd5;
        @(negedge clk);
        in_valid = 1'b0; in_flush = 1'b0;
        check("flush_accept.in_ready", 32'(in_ready), 32'd1);

        in_valid = 1'b1; in_op = 2'b01; in_dividend = 32'd1000; in_divisor = 32'd7;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (15) @(negedge clk);
        in_flush = 1'b1;
        @(negedge clk);
        in_flush = 1'b0;
        check("flush.out_valid", 32'(out_valid), 32'd0);
        check("flush.in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("flush.no_result", 32'(seen), 32'd0);

        in_valid = 1'b1; in_op = 2'b00; in_dividend = 32'd999; in_divisor = 32'd4;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (19) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("reset_mid.in_ready", 32'(in_ready), 32'd1);
        check("reset_mid.out_valid", 32'(out_valid), 32'd0);
        check("reset_mid.out_result", out_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("reset_mid.no_result", 32'(seen), 32'd0);
        run(2'b01, 32'd9, 32'd3, 0, "divu_9_3");

        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (i % 6 == 0) ? 32'd0 : (i % 3 == 1) ? 32'($urandom_range(1, 50)) : $urandom;
            if (i % 4 == 2) rb = -rb;
            if (i % 7 == 5) ra = -32'($urandom_range(1, 1000));
            run(rop, ra, rb, 0, $sformatf("rand%0d_op%0d_%h_%h", i, rop, ra, rb));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/rv32m_divider.md
RV32M_DIVIDER -- requirements
Module: rv32m_divider

Interface
REQ-001 SHALL have parameter W, default 32, the operand and result width.
REQ-002 SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, request valid.
REQ-005 SHALL have port in_ready, output, 1, divider can accept a request.
REQ-006 SHALL have port in_op, input, 2, operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-007 SHALL have port in_dividend, input, W, dividend (rs1).
REQ-008 SHALL have port in_divisor, input, W, divisor (rs2).
REQ-009 SHALL have port in_flush, input, 1, synchronous abort of any in-flight operation.
REQ-010 SHALL have port out_valid, output, 1, result valid.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-012 SHALL have port out_result, output, W, quotient or remainder per in_op.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE; accept on the edge where in_valid & in_ready (edge E0), latching op and operands.
REQ-015 SHALL, for a normal request, go IDLE->CALC at E0, do one restoring iteration per edge E1..E32, reach FIX at E32, and DONE at E33, with out_valid=1 after E33 (33-cycle latency).
REQ-016 SHALL, per iteration, shift {rem[W:0], quot} left by one, form trial = rem - {0,divisor} at W+1 bits, keep trial and set quotient LSB=1 if trial >= 0, else restore and set LSB=0.
REQ-017 SHALL, for DIV/REM, divide operand magnitudes; in FIX, negate the quotient when operand signs differ and give the remainder the dividend's sign; DIVU/REMU pass through FIX unchanged.
REQ-018 SHALL, on divisor==0, skip CALC and enter DONE at E1 with quotient = all ones and remainder = dividend (all ops).
REQ-019 SHALL, on DIV/REM with dividend=0x80000000 and divisor=0xFFFFFFFF, skip CALC and enter DONE at E1 with quotient=0x80000000 and remainder=0.
REQ-020 SHALL hold out_valid and out_result stable in DONE until out_valid & out_ready, then return to IDLE on that edge; in_ready=1 from the next cycle only (no same-cycle re-accept).
REQ-021 SHALL use a 6-bit iteration counter that saturates the CALC->FIX transition at exactly 32 iterations, never wrapping.
REQ-022 SHALL, on in_flush=1 in any state, return to IDLE on the next edge, clear out_valid and discard the result; a flush coincident with an accept cancels the accept.
REQ-023 SHALL give out_result=0 whenever out_valid=0.

Reset
REQ-024 SHALL, on rst_n low at any time including mid-CALC, asynchronously force IDLE, counter=0, out_valid=0, out_result=0, in_ready=1 after release.
REQ-025 SHALL clear all internal operand, remainder and quotient registers on reset.

Structure
REQ-026 SHALL take op encodings, FSM state encodings and the iteration count (32) from the shared rv32m_pkg.
REQ-027 SHALL instantiate one carry_lookahead_adder (W+1 bits) for the trial subtraction (in_b=~divisor, in_cin=1), multiplexed in FIX for two's-complement negation (in_a=~x, in_b=0, in_cin=1).

Verification
REQ-028 SHALL check DIVU 100/7 -> 14 and REMU 100/7 -> 2, with out_valid exactly 33 cycles after accept.
REQ-029 SHALL check DIV -7/2 -> 0xFFFFFFFD and REM -7/2 -> 0xFFFFFFFF; DIV 7/-2 -> 0xFFFFFFFD, REM 7/-2 -> 1.
REQ-030 SHALL check DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, with out_valid one cycle after accept.
REQ-031 SHALL check DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0, with 1-cycle latency.
REQ-032 SHALL hold out_ready low for 10 cycles in DONE -> out_result stable, in_ready=0; then assert out_ready -> IDLE and in_ready=1 on the following cycle.
REQ-033 SHALL assert in_flush at iteration 16, then separately rst_n low at iteration 20 -> IDLE, out_valid=0, no result emitted; the next request (DIVU 9/3) returns 3.
